// File: rtl/serial_word_tx.sv
// rtl/serial_word_tx.sv - framed parallel-to-serial word transmitter (start, MSB-first data, odd parity, stop, gap)
module serial_word_tx #(
  parameter int WIDTH      = 8,
  parameter bit IDLE_LEVEL = 1'b1,
  parameter int GAP_CYCLES = 1
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  output logic             DOUT,
  output logic             DOUT_EN,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_GAP
  } state_t;

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [3:0]      GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t             state, state_n;
  logic [WIDTH-1:0]   shreg, shreg_n;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_n;
  logic [3:0]         gap_cnt, gap_cnt_n;
  logic               parity, parity_n;
  logic               dout_n, dout_en_n, din_ready_n, busy_n, done_n;
  logic               accept;

  assign accept = DIN_VALID & DIN_READY;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      parity    <= 1'b0;
      DOUT      <= IDLE_LEVEL;
      DOUT_EN   <= 1'b0;
      DIN_READY <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      bit_cnt   <= bit_cnt_n;
      gap_cnt   <= gap_cnt_n;
      parity    <= parity_n;
      DOUT      <= dout_n;
      DOUT_EN   <= dout_en_n;
      DIN_READY <= din_ready_n;
      BUSY      <= busy_n;
      DONE      <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    gap_cnt_n = gap_cnt;
    parity_n  = parity;
    dout_n    = IDLE_LEVEL;
    dout_en_n = 1'b0;

    case (state)
      S_IDLE: begin
        if (accept) begin
          state_n  = S_START;
          shreg_n  = DIN;
          parity_n = ~(^DIN);
        end
      end
      S_START: begin
        state_n   = S_DATA;
        bit_cnt_n = '0;
      end
      S_DATA: begin
        if (bit_cnt == BIT_LAST) state_n = S_PARITY;
        else                     bit_cnt_n = bit_cnt + CNT_W'(1);
      end
      S_PARITY: state_n = S_STOP;
      S_STOP: begin
        gap_cnt_n = 4'd0;
        state_n   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_n = S_IDLE;
        else                     gap_cnt_n = gap_cnt + 4'd1;
      end
      default: state_n = S_IDLE;
    endcase

    // Outputs are decoded from the state being entered so they register on that same edge.
    case (state_n)
      S_START: begin
        dout_n    = ~IDLE_LEVEL;
        dout_en_n = 1'b1;
      end
      S_DATA: begin
        dout_n    = shreg[WIDTH-1];
        dout_en_n = 1'b1;
        shreg_n   = {shreg[WIDTH-2:0], 1'b0};
      end
      S_PARITY: begin
        dout_n    = parity;
        dout_en_n = 1'b1;
      end
      default: ;
    endcase

    din_ready_n = (state_n == S_IDLE);
    busy_n      = (state_n != S_IDLE);
    done_n      = (state == S_STOP);
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// tb/tb_serial_word_tx.sv - directed self-checking bench for serial_word_tx
module tb_serial_word_tx;

  logic       CLK;
  logic       CLR;
  logic [7:0] din1, din0;
  logic       vld1, vld0;
  logic       rdy1, dout1, en1, busy1, done1;
  logic       rdy0, dout0, en0, busy0, done0;

  int n_checks = 0;
  int n_errors = 0;

  serial_word_tx #(.WIDTH(8), .IDLE_LEVEL(1'b1), .GAP_CYCLES(1)) dut (
    .CLK(CLK), .CLR(CLR), .DIN(din1), .DIN_VALID(vld1), .DIN_READY(rdy1),
    .DOUT(dout1), .DOUT_EN(en1), .BUSY(busy1), .DONE(done1)
  );

  serial_word_tx #(.WIDTH(8), .IDLE_LEVEL(1'b1), .GAP_CYCLES(0)) dut0 (
    .CLK(CLK), .CLR(CLR), .DIN(din0), .DIN_VALID(vld0), .DIN_READY(rdy0),
    .DOUT(dout0), .DOUT_EN(en0), .BUSY(busy0), .DONE(done0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_rdy1(input string tag);
    for (int t = 0; t < 40 && !rdy1; t++) step();
    check({tag, "_ready"}, rdy1, 1'b1);
  endtask

  // Send one word on the GAP_CYCLES=1 instance and check the whole frame against a hand-written line pattern.
  task automatic send1(input logic [7:0] w, input logic [10:0] pat, input string tag);
    logic [10:0] line;
    logic [10:0] en;
    int          done_cnt;
    line = '0;
    en = '0;
    done_cnt = 0;
    din1 = w;
    vld1 = 1'b1;
    wait_rdy1(tag);
    step();
    vld1 = 1'b0;
    din1 = ~w;
    for (int i = 0; i < 11; i++) begin
      line = {line[9:0], dout1};
      en   = {en[9:0], en1};
      if (done1) done_cnt++;
      step();
    end
    check({tag, "_line"}, line, pat);
    check({tag, "_en"}, en, 11'b11111111110);
    check({tag, "_early_done"}, done_cnt, 0);
    check({tag, "_done"}, done1, 1'b1);
    check({tag, "_gap_rdy"}, {busy1, rdy1, dout1}, 3'b101);
    step();
    check({tag, "_end"}, {busy1, rdy1, done1, dout1}, 4'b0101);
  endtask

  initial begin
    logic [23:0] line0, en0_seq, done0_seq;
    int          cnt;
    int          done_seen;

    CLR = 1'b0;
    din1 = 8'h00; vld1 = 1'b0;
    din0 = 8'h00; vld0 = 1'b0;

    repeat (3) step();
    check("rst_outs", {dout1, en1, busy1, rdy1, done1}, 5'b10000);
    check("rst_outs0", {dout0, en0, busy0, rdy0, done0}, 5'b10000);
    CLR = 1'b1;
    step();
    check("idle_first_edge", {dout1, en1, busy1, rdy1}, 4'b1001);
    check("idle_first_edge0", rdy0, 1'b1);

    send1(8'hA5, 11'b0_10100101_1_1, "a5");
    send1(8'h00, 11'b0_00000000_1_1, "p00");
    send1(8'hFF, 11'b0_11111111_1_1, "pff");
    send1(8'h01, 11'b0_00000001_0_1, "p01");

    // Stall: valid held with DIN changing while busy; nothing may be accepted before ready returns.
    din1 = 8'h00;
    vld1 = 1'b1;
    check("stall_pre_rdy", rdy1, 1'b1);
    step();
    cnt = 0;
    while (!rdy1 && cnt < 40) begin
      din1 = 8'(cnt * 37 + 11);
      step();
      cnt++;
    end
    check("stall_cycles", cnt, 12);
    send1(8'h5A, 11'b0_01011010_1_1, "stall_5a");

    // Back-to-back with no gap on the second instance.
    din0 = 8'h3C;
    vld0 = 1'b1;
    for (int t = 0; t < 40 && !rdy0; t++) step();
    check("b2b_ready", rdy0, 1'b1);
    step();
    line0 = '0; en0_seq = '0; done0_seq = '0;
    for (int i = 0; i < 24; i++) begin
      line0     = {line0[22:0], dout0};
      en0_seq   = {en0_seq[22:0], en0};
      done0_seq = {done0_seq[22:0], done0};
      if (i == 0) din0 = 8'hC3;
      if (i == 23) vld0 = 1'b0;
      step();
    end
    check("b2b_line", line0, 24'h1E761F);
    check("b2b_en", en0_seq, 24'hFFCFFC);
    check("b2b_done", done0_seq, 24'h001001);
    check("b2b_idle", {busy0, rdy0}, 2'b01);

    // Reset during the 4th data bit of F0.
    din1 = 8'hF0;
    vld1 = 1'b1;
    wait_rdy1("f0");
    step();
    vld1 = 1'b0;
    repeat (4) step();
    check("f0_bit4", {dout1, en1, busy1}, 3'b111);
    CLR = 1'b0;
    #1;
    check("abort_async", {dout1, en1, busy1, rdy1}, 4'b1000);
    done_seen = 0;
    repeat (2) begin
      step();
      done_seen += int'(done1);
    end
    CLR = 1'b1;
    repeat (3) begin
      step();
      done_seen += int'(done1);
    end
    check("abort_no_done", done_seen, 0);
    check("abort_rdy", rdy1, 1'b1);
    send1(8'h81, 11'b0_10000001_1_1, "p81");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
